rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares one synchronous-read block RAM (1-cycle read latency, 32-bit words, byte-addressed)
//  between an instruction-fetch port and a data-load port of the core.
//  Each port uses a req/gnt/rvalid handshake.
//  Conflicting requests are arbitrated round-robin, and each read response is steered back to its owner.
//  Out-of-range and misaligned reads are flagged.
//  Sits between the core fetch/LSU ports and the BRAM wrapper in the testbench and SoC top.
// PARAMETERS
//  MEM_SIZE_WORDS  2**12  depth of the attached memory, in 32-bit words
//  RESET_PRIO_D    0      port that wins the first conflict after reset: 0 = instr, 1 = data
// PORTS
//  clk_i         in   1   clock; everything is sampled on the rising edge
//  rstn_i        in   1   reset; synchronous, active-low
//  ireq_i        in   1   instr port request
//  iaddr_i       in   32  instr byte address; must stay stable while ireq_i=1 and igrant_o=0
//  igrant_o      out  1   instr request accepted this cycle
//  irvalid_o     out  1   instr response valid; asserted exactly 1 cycle after igrant_o
//  irdata_o      out  32  instr read data; 0 when the response has an error
//  ierr_o        out  1   instr response error; qualified by irvalid_o
//  dreq_i, daddr_i, dgrant_o, drvalid_o, drdata_o, derr_o
//                         same as the instr set, for the data port
//  mem_addr_o    out  32  address driven to the BRAM
//  mem_rdata_i   in   32  BRAM read data for the address presented in the previous cycle
// BEHAVIOUR
//  - Grant logic is combinational, so a grant can fall in the same cycle as the request.
//    - At most one grant per cycle; back-to-back grants are allowed, giving 1 read/cycle throughput.
//    - Only one requester active: that requester is granted, and the priority pointer is unchanged.
//    - Both requesting: the port named by prio_q wins.
//      prio_q then moves to the loser, and the loser is granted in the next cycle if it still requests.
//    - While rstn_i=0, both grants are forced to 0.
//  - mem_addr_o:
//    - Carries the winner's address in the grant cycle.
//    - In a cycle with no grant, holds last_addr_q, the last granted address; it resets to 0.
//  - Error check, in the grant cycle: addr[1:0]!=0, or addr >= MEM_SIZE_WORDS*4, sets err.
//    An erroring request is still granted and still gets exactly one response.
//  - Response stage (registers rsp_vld_q, rsp_port_q, rsp_err_q), cycle after a grant:
//    - x_rvalid_o=1 for the granted port only; the other port's rvalid stays 0.
//    - rdata = rsp_err_q ? 0 : mem_rdata_i; x_err_o = rsp_err_q.
//    - rdata and err are 0 whenever rvalid=0.
//    - Requesters cannot stall responses; there is no rready.
//  - Reset values: all rvalid/err/rdata outputs 0, rsp_vld_q=0, prio_q=RESET_PRIO_D, last_addr_q=0.
//  - Reset asserted while a response is pending: the response is dropped.
//    No rvalid appears in the cycle after reset is sampled.
//    The first grant after reset deassertion behaves as a fresh start.
//  - Address arithmetic: the range compare is done at 33 bits, so addr = 32'hFFFF_FFFC does not wrap.
//  - Request withdrawn before grant: this is illegal, and an SVA flags it.
//  - Request held after grant: each cycle it stays high counts as a new request, giving a new read.
// STRUCTURE
//  - Shared package rom_arb_pkg:
//    - typedef enum logic {PORT_I=1'b0, PORT_D=1'b1} arb_port_e
//    - localparam ADDR_W=32, DATA_W=32
//    - typedef struct {vld, port, err} rsp_tag_t
//  - One sub-module, rr_arb2: a 2-way round-robin arbiter.
//    It takes req[1:0] and returns a one-hot gnt[1:0], and owns prio_q.
//  - The top level holds the address mux, error check, last_addr_q and the response steering.
// TESTING
//  1. Lone fetch, ireq=1, iaddr=0x10, BRAM word[4]=0xDEADBEEF
//     -> igrant in the same cycle, mem_addr_o=0x10;
//        next cycle irvalid=1, irdata=0xDEADBEEF, drvalid=0.
//  2. Conflict from reset, RESET_PRIO_D=0, iaddr=0x0, daddr=0x4, both held
//     -> cycle 0: igrant; cycle 1: dgrant and irvalid; cycle 2: drvalid with word[1].
//  3. Sustained conflict for 6 cycles -> grants alternate I,D,I,D,I,D and no port gets two in a row.
//  4. Error cases
//     -> daddr=0x4002: drvalid=1, derr=1, drdata=0.
//     -> daddr=MEM_SIZE_WORDS*4 (0x4000): derr=1.
//     -> daddr=0x3FFC: derr=0, valid data.
//  5. Reset mid-operation: grant in cycle N, rstn_i=0 in cycle N+1
//     -> no rvalid in N+1; after release, prio_q is back to RESET_PRIO_D.
//  6. Idle after a grant -> mem_addr_o holds the last granted address and no rvalid pulses appear.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the two-port BRAM read arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic      vld;
    arb_port_e port;
    logic      err;
  } rsp_tag_t;

  // Compare one bit wider than the address so the top of the address space cannot wrap.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W:0]   limit_bytes);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ({1'b0, addr} >= limit_bytes);
    return misaligned | out_of_range;
  endfunction

  function automatic arb_port_e other_port(input arb_port_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_chk.sv
// Protocol checks for the arbiter ports; simulation-only properties.
module rom_port_arbiter_chk (
  input logic        clk_i,
  input logic        rstn_i,
  input logic        ireq_i,
  input logic [31:0] iaddr_i,
  input logic        igrant_i,
  input logic        irvalid_i,
  input logic        dreq_i,
  input logic [31:0] daddr_i,
  input logic        dgrant_i,
  input logic        drvalid_i
);

  a_ireq_held: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (ireq_i && !igrant_i) |=> ireq_i);

  a_dreq_held: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (dreq_i && !dgrant_i) |=> dreq_i);

  a_iaddr_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (ireq_i && !igrant_i) |=> $stable(iaddr_i));

  a_daddr_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (dreq_i && !dgrant_i) |=> $stable(daddr_i));

  a_one_grant: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(igrant_i && dgrant_i));

  a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(irvalid_i && drvalid_i));

endmodule

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; owns the priority pointer.
module rr_arb2
  import rom_arb_pkg::*;
#(
  parameter arb_port_e RESET_PRIO = PORT_I
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  arb_port_e prio_q;
  arb_port_e prio_d;

  // Priority pointer register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prio_q <= RESET_PRIO;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant decode; the pointer only moves on a genuine conflict
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (!rstn_i) begin
      gnt_o  = 2'b00;
      prio_d = prio_q;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          gnt_o  = (prio_q == PORT_I) ? 2'b01 : 2'b10;
          prio_d = other_port(prio_q);
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one 1-cycle-latency BRAM between instruction-fetch and data-load ports,
// steering each read response back to the port that was granted.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = 2**12,
  parameter bit          RESET_PRIO_D   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              igrant_o,
  output logic              irvalid_o,
  output logic [DATA_W-1:0] irdata_o,
  output logic              ierr_o,
  input  logic              dreq_i,
  input  logic [ADDR_W-1:0] daddr_i,
  output logic              dgrant_o,
  output logic              drvalid_o,
  output logic [DATA_W-1:0] drdata_o,
  output logic              derr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_SIZE_WORDS) * 33'd4;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] last_addr_d;
  rsp_tag_t          rsp_q;
  rsp_tag_t          rsp_d;
  logic              rsp_live;

  assign req = {dreq_i, ireq_i};

  rr_arb2 #(
    .RESET_PRIO (arb_port_e'(RESET_PRIO_D))
  ) u_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign igrant_o = gnt[PORT_I];
  assign dgrant_o = gnt[PORT_D];
  assign any_gnt  = |gnt;

  // Address mux, error tagging and next-state for the response stage
  always_comb begin
    win_addr    = iaddr_i;
    last_addr_d = last_addr_q;
    rsp_d       = '{vld: 1'b0, port: PORT_I, err: 1'b0};
    if (gnt[PORT_D]) begin
      win_addr = daddr_i;
    end else begin
      win_addr = iaddr_i;
    end
    if (any_gnt) begin
      last_addr_d = win_addr;
      rsp_d.vld   = 1'b1;
      rsp_d.port  = gnt[PORT_D] ? PORT_D : PORT_I;
      rsp_d.err   = addr_err(win_addr, MEM_BYTES);
    end else begin
      last_addr_d = last_addr_q;
    end
  end

  assign mem_addr_o = any_gnt ? win_addr : last_addr_q;

  // Response tag and last-address registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rsp_q       <= '{vld: 1'b0, port: PORT_I, err: 1'b0};
      last_addr_q <= '0;
    end else begin
      rsp_q       <= rsp_d;
      last_addr_q <= last_addr_d;
    end
  end

  // A pending response is dropped as soon as reset is asserted
  assign rsp_live = rsp_q.vld & rstn_i;

  // Steer the BRAM data to the owning port; everything idles at zero
  always_comb begin
    irvalid_o = 1'b0;
    ierr_o    = 1'b0;
    irdata_o  = 32'h0000_0000;
    drvalid_o = 1'b0;
    derr_o    = 1'b0;
    drdata_o  = 32'h0000_0000;
    if (rsp_live) begin
      case (rsp_q.port)
        PORT_I: begin
          irvalid_o = 1'b1;
          ierr_o    = rsp_q.err;
          irdata_o  = rsp_q.err ? 32'h0000_0000 : mem_rdata_i;
        end
        PORT_D: begin
          drvalid_o = 1'b1;
          derr_o    = rsp_q.err;
          drdata_o  = rsp_q.err ? 32'h0000_0000 : mem_rdata_i;
        end
        default: begin
          irvalid_o = 1'b0;
          drvalid_o = 1'b0;
        end
      endcase
    end else begin
      irvalid_o = 1'b0;
      drvalid_o = 1'b0;
    end
  end

  rom_port_arbiter_chk u_chk (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .ireq_i    (ireq_i),
    .iaddr_i   (iaddr_i),
    .igrant_i  (igrant_o),
    .irvalid_i (irvalid_o),
    .dreq_i    (dreq_i),
    .daddr_i   (daddr_i),
    .dgrant_i  (dgrant_o),
    .drvalid_i (drvalid_o)
  );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural 1-cycle BRAM.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        ireq;
  logic [31:0] iaddr;
  logic        igrant;
  logic        irvalid;
  logic [31:0] irdata;
  logic        ierr;
  logic        dreq;
  logic [31:0] daddr;
  logic        dgrant;
  logic        drvalid;
  logic [31:0] drdata;
  logic        derr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:4095];
  int n_assert;
  int n_fail;

  rom_port_arbiter #(
    .MEM_SIZE_WORDS (4096),
    .RESET_PRIO_D   (1'b0)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .ireq_i      (ireq),
    .iaddr_i     (iaddr),
    .igrant_o    (igrant),
    .irvalid_o   (irvalid),
    .irdata_o    (irdata),
    .ierr_o      (ierr),
    .dreq_i      (dreq),
    .daddr_i     (daddr),
    .dgrant_o    (dgrant),
    .drvalid_o   (drvalid),
    .drdata_o    (drdata),
    .derr_o      (derr),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr[13:2]];

  function automatic logic [31:0] w(input int idx);
    if (idx == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    ireq  = ir;
    iaddr = ia;
    dreq  = dr;
    daddr = da;
    #2;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = w(i);
    rstn = 1'b0;
    set_in(1'b1, 32'h0, 1'b1, 32'h4);
    tick();
    tick();
    chk("rst_igrant", {31'd0, igrant}, 32'd0);
    chk("rst_dgrant", {31'd0, dgrant}, 32'd0);
    chk("rst_irvalid", {31'd0, irvalid}, 32'd0);
    chk("rst_drvalid", {31'd0, drvalid}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    rstn = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // lone fetch
    set_in(1'b1, 32'h10, 1'b0, 32'h0);
    chk("t1_igrant", {31'd0, igrant}, 32'd1);
    chk("t1_dgrant", {31'd0, dgrant}, 32'd0);
    chk("t1_maddr", mem_addr, 32'h10);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_irvalid", {31'd0, irvalid}, 32'd1);
    chk("t1_irdata", irdata, 32'hDEAD_BEEF);
    chk("t1_ierr", {31'd0, ierr}, 32'd0);
    chk("t1_drvalid", {31'd0, drvalid}, 32'd0);
    tick();

    // conflict with instr priority
    set_in(1'b1, 32'h0, 1'b1, 32'h4);
    chk("t2_c0_igrant", {31'd0, igrant}, 32'd1);
    chk("t2_c0_dgrant", {31'd0, dgrant}, 32'd0);
    chk("t2_c0_maddr", mem_addr, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h4);
    chk("t2_c1_dgrant", {31'd0, dgrant}, 32'd1);
    chk("t2_c1_igrant", {31'd0, igrant}, 32'd0);
    chk("t2_c1_irvalid", {31'd0, irvalid}, 32'd1);
    chk("t2_c1_irdata", irdata, w(0));
    chk("t2_c1_maddr", mem_addr, 32'h4);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_c2_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t2_c2_drdata", drdata, w(1));
    chk("t2_c2_irvalid", {31'd0, irvalid}, 32'd0);
    tick();

    // fresh reset so the sustained conflict starts from instr priority
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    set_in(1'b1, 32'h20, 1'b1, 32'h24);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_igrant_%0d", k), {31'd0, igrant}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_dgrant_%0d", k), {31'd0, dgrant}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("t3_irvalid_%0d", k), {31'd0, irvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("t3_drvalid_%0d", k), {31'd0, drvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick();
      #2;
    end
    set_in(1'b1, 32'h20, 1'b0, 32'h0);
    chk("t3_tail_igrant", {31'd0, igrant}, 32'd1);
    chk("t3_tail_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t3_tail_drdata", drdata, w(9));
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_last_irvalid", {31'd0, irvalid}, 32'd1);
    chk("t3_last_irdata", irdata, w(8));
    chk("t3_last_drvalid", {31'd0, drvalid}, 32'd0);
    tick();

    // error cases, back-to-back data reads
    set_in(1'b0, 32'h0, 1'b1, 32'h4002);
    chk("t4_dgrant", {31'd0, dgrant}, 32'd1);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h4000);
    chk("t4_mis_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t4_mis_derr", {31'd0, derr}, 32'd1);
    chk("t4_mis_drdata", drdata, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 32'h3FFC);
    chk("t4_oor_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t4_oor_derr", {31'd0, derr}, 32'd1);
    chk("t4_oor_drdata", drdata, 32'h0);
    tick();
    set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("t4_top_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t4_top_derr", {31'd0, derr}, 32'd0);
    chk("t4_top_drdata", drdata, w(4095));
    chk("t4_wrap_igrant", {31'd0, igrant}, 32'd1);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t4_wrap_irvalid", {31'd0, irvalid}, 32'd1);
    chk("t4_wrap_ierr", {31'd0, ierr}, 32'd1);
    chk("t4_wrap_irdata", irdata, 32'h0);
    tick();

    // reset mid-operation; the conflict moves priority to data first
    set_in(1'b1, 32'h8, 1'b1, 32'hC);
    chk("t5_igrant", {31'd0, igrant}, 32'd1);
    tick();
    rstn = 1'b0;
    #2;
    chk("t5_rst_irvalid", {31'd0, irvalid}, 32'd0);
    chk("t5_rst_drvalid", {31'd0, drvalid}, 32'd0);
    chk("t5_rst_igrant", {31'd0, igrant}, 32'd0);
    chk("t5_rst_dgrant", {31'd0, dgrant}, 32'd0);
    tick();
    rstn = 1'b1;
    #2;
    chk("t5_rel_irvalid", {31'd0, irvalid}, 32'd0);
    chk("t5_rel_igrant", {31'd0, igrant}, 32'd1);
    chk("t5_rel_dgrant", {31'd0, dgrant}, 32'd0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 32'hC);
    chk("t5_dgrant", {31'd0, dgrant}, 32'd1);
    chk("t5_irvalid", {31'd0, irvalid}, 32'd1);
    chk("t5_irdata", irdata, w(2));
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_drvalid", {31'd0, drvalid}, 32'd1);
    chk("t5_drdata", drdata, w(3));
    chk("t5_maddr", mem_addr, 32'hC);
    tick();

    // idle: address holds, no stray responses
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6_maddr_%0d", k), mem_addr, 32'hC);
      chk($sformatf("t6_irvalid_%0d", k), {31'd0, irvalid}, 32'd0);
      chk($sformatf("t6_drvalid_%0d", k), {31'd0, drvalid}, 32'd0);
      tick();
      #2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
